// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with an output FIFO.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   in                  asynchronous serial line, idle high
//   c_addr/c_data       config register write port
//   c_valid/c_ready     config handshake; c_ready is high only while the receiver is idle
//   error/valid_error   {overrun, framing, parity} with a one-cycle qualifying pulse
//   out/valid_out       FIFO head (zero-extended) and FIFO non-empty
//   ready_out           consumer pop, taken when valid_out & ready_out
//
// Config registers at CFG_BASE+0 (mode), +1 (divisor low byte), +2 (divisor high bits).
// The divisor high-byte write assumes 8 < WIDTH_DIV <= 8 + WIDTH_CONFIG_DATA.
module uart_rx_cfg #(
    parameter int unsigned                  WIDTH_CONFIG_ADDR = 4,
    parameter int unsigned                  WIDTH_CONFIG_DATA = 8,
    parameter logic [WIDTH_CONFIG_ADDR-1:0] CFG_BASE          = 4'b0100,
    parameter int unsigned                  OVERSAMPLE        = 16,
    parameter int unsigned                  WIDTH_DIV         = 16,
    parameter int unsigned                  FIFO_DEPTH        = 4,
    parameter int unsigned                  WIDTH_DATABITS    = 8,
    parameter int unsigned                  WIDTH_ERROR       = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in,
    input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
    input  logic                         c_valid,
    output logic                         c_ready,
    output logic [WIDTH_ERROR-1:0]       error,
    output logic                         valid_error,
    output logic [WIDTH_DATABITS-1:0]    out,
    output logic                         valid_out,
    input  logic                         ready_out
);
    localparam int unsigned SW   = $clog2(OVERSAMPLE);
    localparam int unsigned HALF = OVERSAMPLE / 2;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_MODE   = CFG_BASE;
    localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_DIV_LO = WIDTH_CONFIG_ADDR'(CFG_BASE + 1);
    localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_DIV_HI = WIDTH_CONFIG_ADDR'(CFG_BASE + 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                sync_q;
    logic                      line, line_prev_q, fall, start;
    logic [4:0]                mode_q, mode_d;
    logic [WIDTH_DIV-1:0]      div_q, div_d, div_eff, tick_cnt_q, tick_cnt_d;
    logic                      tick, vote, vote_tick;
    logic [SW-1:0]             samp_cnt_q, samp_cnt_d;
    logic                      s0_q, s0_d, s1_q, s1_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d, len_m1;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      par_en, two_stop, last_bit, last_stop;
    logic [WIDTH_DATABITS-1:0] data_q, data_d;
    logic                      par_err_q, par_err_d, frm_err_q, frm_err_d, frm_now;
    logic                      frame_end, push_req, push, pop, full, ovr, err_any;
    logic [WIDTH_ERROR-1:0]    error_q, error_d;
    logic                      valid_error_q;
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [PW:0]               count_q, count_d;
    logic [WIDTH_DATABITS-1:0] mem_q [FIFO_DEPTH];

    // Line conditioning: two-flop synchronizer plus edge history.
    assign line = sync_q[1];
    assign fall = line_prev_q & ~line;

    // Mode decode.
    assign par_en   = mode_q[0] ^ mode_q[1];
    assign two_stop = mode_q[2];
    assign len_m1   = {1'b0, mode_q[4:3]} + 3'd4;

    // Baud tick; restarted on the start edge so bit phase is locked to the frame.
    assign div_eff    = (div_q == '0) ? WIDTH_DIV'(1) : div_q;
    assign tick       = tick_cnt_q >= (div_eff - WIDTH_DIV'(1));
    assign tick_cnt_d = (start || tick) ? '0 : tick_cnt_q + WIDTH_DIV'(1);

    // Majority of the three samples around bit centre; decided on the third sample tick.
    assign vote      = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
    assign vote_tick = tick && (samp_cnt_q == SW'(HALF + 1));
    assign last_bit  = bit_cnt_q == len_m1;
    assign last_stop = stop_cnt_q | ~two_stop;
    assign frm_now   = frm_err_q | ~vote;

    // FIFO status; a pop on a full FIFO makes room for a same-cycle push.
    assign pop  = valid_out & ready_out;
    assign full = count_q == (PW + 1)'(FIFO_DEPTH);

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (fall) state_d = StStart;
            StStart:    if (vote_tick) state_d = vote ? StIdle : StData;
            StData:     if (vote_tick && last_bit) state_d = par_en ? StParity : StStop;
            StParity:   if (vote_tick) state_d = StStop;
            StStop:     if (vote_tick && last_stop) state_d = frm_now ? StWaitHigh : StIdle;
            StWaitHigh: if (line) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        c_ready   = state_q == StIdle;
        start     = (state_q == StIdle) && fall;
        frame_end = (state_q == StStop) && vote_tick && last_stop;
        push_req  = frame_end && !par_err_q && !frm_now;
        push      = push_req && (!full || pop);
        ovr       = push_req && !push;
        err_any   = frame_end && (ovr || frm_now || par_err_q);
        error_d   = err_any ? WIDTH_ERROR'({ovr, frm_now, par_err_q}) : '0;
    end

    // Config next-state; only reachable while idle because c_ready gates it.
    always_comb begin
        mode_d = mode_q;
        div_d  = div_q;
        if (c_valid && c_ready) begin
            if (c_addr == ADDR_MODE)   mode_d = c_data[4:0];
            if (c_addr == ADDR_DIV_LO) div_d[7:0] = c_data[7:0];
            if (c_addr == ADDR_DIV_HI) div_d[WIDTH_DIV-1:8] = c_data[WIDTH_DIV-9:0];
        end
    end

    // Frame datapath next-state.
    always_comb begin
        samp_cnt_d = samp_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        if (start) begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            data_d     = '0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
        end else if (tick) begin
            samp_cnt_d = (samp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + SW'(1);
            if (samp_cnt_q == SW'(HALF - 1)) s0_d = line;
            if (samp_cnt_q == SW'(HALF))     s1_d = line;
            if (vote_tick) begin
                case (state_q)
                    StData: begin
                        data_d[bit_cnt_q] = vote;
                        bit_cnt_d         = bit_cnt_q + 3'd1;
                    end
                    // Data bits above the configured length are zero, so a full XOR is safe.
                    StParity: par_err_d = (^data_q) ^ vote ^ mode_q[1];
                    StStop: begin
                        frm_err_d  = frm_now;
                        stop_cnt_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO occupancy.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (PW + 1)'(1);
        else if (!push && pop) count_d = count_q - (PW + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b11;
            line_prev_q   <= 1'b1;
            mode_q        <= 5'b11000;
            div_q         <= WIDTH_DIV'(1);
            tick_cnt_q    <= '0;
            samp_cnt_q    <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            data_q        <= '0;
            par_err_q     <= 1'b0;
            frm_err_q     <= 1'b0;
            error_q       <= '0;
            valid_error_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sync_q        <= {sync_q[0], in};
            line_prev_q   <= line;
            mode_q        <= mode_d;
            div_q         <= div_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            data_q        <= data_d;
            par_err_q     <= par_err_d;
            frm_err_q     <= frm_err_d;
            error_q       <= error_d;
            valid_error_q <= err_any;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_q;
    end

    assign valid_out   = count_q != '0;
    assign out         = valid_out ? mem_q[rd_ptr_q] : '0;
    assign error       = error_q;
    assign valid_error = valid_error_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
    localparam int         OS    = 16;
    localparam int         DEPTH = 4;
    localparam logic [3:0] BASE  = 4'b0100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in = 1'b1;
    logic [3:0] c_addr = '0;
    logic [7:0] c_data = '0;
    logic       c_valid = 1'b0;
    logic       c_ready;
    logic [2:0] error;
    logic       valid_error;
    logic [7:0] out;
    logic       valid_out;
    logic       ready_out = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .error      (error),
        .valid_error(valid_error),
        .out        (out),
        .valid_out  (valid_out),
        .ready_out  (ready_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard and behavioural model state.
    logic [7:0] exp_data[$];
    logic [2:0] exp_err[$];
    int         model_occ = 0;
    bit         rdy_en = 1'b0;
    bit         rdy_rand = 1'b0;
    int         m_par = 0, m_stop2 = 0, m_len = 8, m_div = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Consumer-side ready, optionally throttled at random.
    initial forever begin
        @(posedge clk);
        #1 ready_out = rdy_en && (!rdy_rand || ($urandom_range(0, 3) != 0));
    end

    // Monitor: pops expectations whenever the DUT presents data or an error.
    logic       hold_q = 1'b0;
    logic [7:0] hold_out = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_q && valid_out) chk("out_stable", out, hold_out);
            if (valid_out && ready_out) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_data: got %0h expected none", out);
                end else begin
                    chk("data", out, exp_data.pop_front());
                    model_occ--;
                end
            end
            if (valid_error) begin
                if (exp_err.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_error: got %0b expected none", error);
                end else begin
                    chk("error", error, exp_err.pop_front());
                end
            end
            hold_q   <= valid_out && !ready_out;
            hold_out <= out;
        end else begin
            hold_q <= 1'b0;
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        c_addr  = a;
        c_data  = d;
        c_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (c_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 c_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg_timeout: got c_ready 0 expected 1");
        end else if (a == BASE) begin
            m_par   = int'(d[1:0]);
            m_stop2 = int'(d[2]);
            m_len   = int'(d[4:3]) + 5;
        end else if (a == BASE + 4'd1) begin
            m_div = (m_div & 'hff00) | int'(d);
        end else if (a == BASE + 4'd2) begin
            m_div = (m_div & 'h00ff) | (int'(d) << 8);
        end
    endtask

    task automatic set_cfg(input int par, input int stop2, input int len, input int div);
        cfg_write(BASE, 8'(par + 4 * stop2 + 8 * (len - 5)));
        cfg_write(BASE + 4'd1, 8'(div & 255));
        cfg_write(BASE + 4'd2, 8'(div >> 8));
    endtask

    task automatic drive_bit(input logic b, input int n);
        @(posedge clk);
        #1 in = b;
        repeat (n - 1) @(posedge clk);
    endtask

    // Builds one frame from the current model config and predicts its outcome.
    task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit stop_low);
        int         len    = m_len;
        int         par    = m_par;
        int         nstop  = m_stop2 ? 2 : 1;
        int         cpb    = OS * ((m_div == 0) ? 1 : m_div);
        logic [7:0] dv     = data & 8'((1 << len) - 1);
        bit         par_on = (par == 1) || (par == 2);
        bit         odd    = (par == 2);
        bit         pbit   = (^dv) ^ odd ^ flip_par;
        bit         perr   = par_on && (((^dv) ^ pbit) != odd);
        bit         ferr   = stop_low;
        bit         ovr    = 1'b0;
        if (!perr && !ferr) begin
            if (model_occ >= DEPTH && !rdy_en) ovr = 1'b1;
            else begin
                exp_data.push_back(dv);
                model_occ++;
            end
        end
        if (perr || ferr || ovr) exp_err.push_back({ovr, ferr, perr});
        drive_bit(1'b0, cpb);
        for (int i = 0; i < len; i++) drive_bit(dv[i], cpb);
        if (par_on) drive_bit(pbit, cpb);
        for (int i = 0; i < nstop; i++) drive_bit(!stop_low, cpb);
        drive_bit(1'b1, 2 * cpb);
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((exp_data.size() != 0 || exp_err.size() != 0) && i < 20000) begin
            @(posedge clk);
            i++;
        end
        if (exp_data.size() != 0 || exp_err.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_%s: got %0d data / %0d errors pending expected 0", tag,
                     exp_data.size(), exp_err.size());
            exp_data.delete();
            exp_err.delete();
        end
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_ready", c_ready, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_valid_error", valid_error, 0);
        chk("rst_error", error, 0);
        chk("rst_out", out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_en = 1'b1;
        repeat (4) @(posedge clk);

        // 8N1 at divisor 4.
        set_cfg(0, 0, 8, 4);
        send_frame(8'hA5, 1'b0, 1'b0);
        drain("a5");

        // Out-of-range config writes are ignored.
        cfg_write(4'h0, 8'h1F);
        cfg_write(4'hF, 8'h02);
        send_frame(8'h96, 1'b0, 1'b0);
        drain("oor");

        // Framing error.
        send_frame(8'h55, 1'b0, 1'b1);
        drain("frame");

        // Break: line low for 20 bit times gives one error and no restart until high.
        exp_err.push_back(3'b010);
        drive_bit(1'b0, 20 * 64);
        @(negedge clk);
        chk("break_wait_high", c_ready, 0);
        drive_bit(1'b1, 6);
        @(negedge clk);
        chk("break_rearm", c_ready, 1);
        drive_bit(1'b1, 128);
        drain("break");

        // Short low glitch is rejected silently.
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 192);
        @(negedge clk);
        chk("glitch_idle", c_ready, 1);
        drain("glitch");

        // Overrun: fifth frame with a full FIFO and no consumer.
        rdy_en = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_valid_out", valid_out, 1);
        chk("ovr_head", out, 8'h01);
        chk("ovr_err_seen", exp_err.size(), 0);
        rdy_en = 1'b1;
        drain("overrun");

        // Config write issued mid-frame waits for idle; then 7E2.
        fork
            send_frame(8'h3C, 1'b0, 1'b0);
        join_none
        repeat (128) @(posedge clk);
        @(negedge clk);
        chk("busy_c_ready", c_ready, 0);
        cfg_write(BASE, 8'h15);
        wait fork;
        drain("midcfg");
        send_frame(8'h35, 1'b0, 1'b0);
        send_frame(8'h35, 1'b1, 1'b0);
        drain("7e2");

        // Reset mid-DATA with two entries queued.
        set_cfg(0, 0, 8, 4);
        rdy_en = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid_out", valid_out, 1);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 40);
        @(posedge clk);
        #3 rst_n = 1'b0;
        in = 1'b1;
        exp_data.delete();
        exp_err.delete();
        model_occ = 0;
        m_par = 0;
        m_stop2 = 0;
        m_len = 8;
        m_div = 1;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_c_ready", c_ready, 1);
        chk("midrst_out", out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_en = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'h5A, 1'b0, 1'b0);
        drain("post_rst");

        // Randomized frames and configs with a throttled consumer.
        rdy_rand = 1'b1;
        for (int n = 0; n < 12; n++) begin
            int par   = $urandom_range(0, 3);
            int stop2 = $urandom_range(0, 1);
            int len   = $urandom_range(5, 8);
            int div   = $urandom_range(0, 3);
            bit flip  = ((par == 1) || (par == 2)) && ($urandom_range(0, 3) == 0);
            bit slow  = $urandom_range(0, 5) == 0;
            set_cfg(par, stop2, len, div);
            send_frame(8'($urandom), flip, slow);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
